// File: rtl/pio_fifo_if.sv
// Bus-side bundle of the PIO FIFO: write/read strobes, data and status.
// The slave modport is the FIFO itself; master is whoever drives the strobes.
interface pio_fifo_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
);

  // Mode select (double-depth when set); "join" itself is a reserved word
  logic                        join_mode;
  logic                        push;
  logic [WIDTH-1:0]            din;
  logic                        pull;
  logic [WIDTH-1:0]            dout;
  logic                        empty;
  logic                        full;
  logic [$clog2(2*DEPTH):0]    level;
  logic                        overflow;
  logic                        underflow;
  logic                        clear_flags;

  modport master (
    output join_mode,
    output push,
    output din,
    output pull,
    output clear_flags,
    input  dout,
    input  empty,
    input  full,
    input  level,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  join_mode,
    input  push,
    input  din,
    input  pull,
    input  clear_flags,
    output dout,
    output empty,
    output full,
    output level,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/pio_fifo.sv
// Per-state-machine first-word-fall-through FIFO for the PIO block.
// Used as TX (bus pushes, machine pulls) or RX (machine pushes, bus pulls).
// Join mode merges both halves of storage into one queue of 2*DEPTH words.
// DEPTH must be a power of two so pointer wrap reduces to a bit mask.
module pio_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic        clk,
  input logic        reset,
  pio_fifo_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(2 * DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  localparam logic [LvlW-1:0] CapNorm  = LvlW'(DEPTH);
  localparam logic [LvlW-1:0] CapJoin  = LvlW'(2 * DEPTH);
  localparam logic [PtrW-1:0] MaskNorm = PtrW'(DEPTH - 1);
  localparam logic [PtrW-1:0] MaskJoin = PtrW'(2 * DEPTH - 1);

  // Storage is never reset; only pointers and level define validity.
  logic [WIDTH-1:0] mem_q [2*DEPTH];

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            join_q;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic [LvlW-1:0] cap;
  logic [PtrW-1:0] ptr_mask;
  logic            full;
  logic            empty;
  logic            join_change;
  logic            wr_en;
  logic            rd_en;
  logic            ovf_set;
  logic            unf_set;

  // Capacity and status come from registered state only, so no push/din
  // path reaches any output. Outside a flush cycle join == join_q.
  always_comb begin
    cap         = join_q ? CapJoin : CapNorm;
    ptr_mask    = join_q ? MaskJoin : MaskNorm;
    full        = (level_q == cap);
    empty       = (level_q == '0);
    join_change = (bus.join_mode != join_q);
  end

  // Acceptance decisions from pre-edge state; a flush cycle blocks everything.
  always_comb begin
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!join_change) begin
      // A pull while full frees a slot in the same edge, so the push lands.
      wr_en   = bus.push && (!full || bus.pull);
      rd_en   = bus.pull && !empty;
      ovf_set = bus.push && full && !bus.pull;
      unf_set = bus.pull && empty;
    end
  end

  // Next-state for pointers, level and sticky flags.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (join_change) begin
      // Mode change discards contents; flags are left untouched.
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      // Masking keeps the MSB at 0 in normal mode.
      if (wr_en) begin
        wptr_d = (wptr_q + 1'b1) & ptr_mask;
      end
      if (rd_en) begin
        rptr_d = (rptr_q + 1'b1) & ptr_mask;
      end
      if (wr_en && !rd_en) begin
        level_d = level_q + 1'b1;
      end else if (rd_en && !wr_en) begin
        level_d = level_q - 1'b1;
      end

      // Set beats clear when both happen in the same cycle.
      if (ovf_set) begin
        overflow_d = 1'b1;
      end else if (bus.clear_flags) begin
        overflow_d = 1'b0;
      end
      if (unf_set) begin
        underflow_d = 1'b1;
      end else if (bus.clear_flags) begin
        underflow_d = 1'b0;
      end
    end
  end

  // Control state register; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      join_q      <= bus.join_mode;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      join_q      <= bus.join_mode;
    end
  end

  // Data array write; suppressed under reset so a held word is not disturbed.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wptr_q] <= bus.din;
    end
  end

  // First-word-fall-through head, forced to zero when nothing is held.
  always_comb begin
    bus.dout      = empty ? '0 : mem_q[rptr_q];
    bus.empty     = empty;
    bus.full      = full;
    bus.level     = level_q;
    bus.overflow  = overflow_q;
    bus.underflow = underflow_q;
  end

endmodule

// File: tb/tb_pio_fifo.sv
// Directed bench for pio_fifo. Stimulus queues each word it expects to be
// read back; a negedge monitor pops and compares on every accepted pull.
module tb_pio_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic reset;

  pio_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pio_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [WIDTH-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pull must present the oldest queued word.
  always @(negedge clk) begin
    if (!reset && bus.pull && !bus.empty) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL pop_unexpected: got 0x%08h, expected no word", bus.dout);
      end else begin
        check("pop_data", bus.dout, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.push        = 1'b0;
    bus.pull        = 1'b0;
    bus.clear_flags = 1'b0;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w, input bit expect_read);
    bus.push = 1'b1;
    bus.din  = w;
    if (expect_read) exp_q.push_back(w);
    tick();
    bus.push = 1'b0;
  endtask

  task automatic pull_n(input int n);
    bus.pull = 1'b1;
    for (int i = 0; i < n; i++) tick();
    bus.pull = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.join_mode = 1'b0;
    bus.din       = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_dout", bus.dout, 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_unf", 32'(bus.underflow), 32'd0);

    // Fill normal mode, then overflow
    push_word(32'h1111_1111, 1'b1);
    check("fwft_head", bus.dout, 32'h1111_1111);
    push_word(32'h2222_2222, 1'b1);
    push_word(32'h3333_3333, 1'b1);
    check("full_at3", 32'(bus.full), 32'd0);
    push_word(32'h4444_4444, 1'b1);
    check("full_at4", 32'(bus.full), 32'd1);
    check("level_4", 32'(bus.level), 32'd4);
    push_word(32'h5555_5555, 1'b0);
    check("ovf_set", 32'(bus.overflow), 32'd1);
    check("level_after_ovf", 32'(bus.level), 32'd4);
    pull_n(4);
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_dout", bus.dout, 32'd0);
    bus.clear_flags = 1'b1;
    tick();
    idle();
    check("ovf_cleared", 32'(bus.overflow), 32'd0);

    // Push and pull together while full
    for (int i = 1; i <= 4; i++) push_word(32'(i), 1'b1);
    bus.push = 1'b1;
    bus.pull = 1'b1;
    bus.din  = 32'hAAAA_0000;
    exp_q.push_back(32'hAAAA_0000);
    tick();
    idle();
    check("full_pp_level", 32'(bus.level), 32'd4);
    check("full_pp_ovf", 32'(bus.overflow), 32'd0);
    check("full_pp_head", bus.dout, 32'd2);
    pull_n(4);
    check("full_pp_empty", 32'(bus.empty), 32'd1);

    // Push and pull together while empty
    bus.push = 1'b1;
    bus.pull = 1'b1;
    bus.din  = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    idle();
    check("empty_pp_unf", 32'(bus.underflow), 32'd1);
    check("empty_pp_level", 32'(bus.level), 32'd1);
    check("empty_pp_dout", bus.dout, 32'hDEAD_BEEF);
    pull_n(1);
    bus.clear_flags = 1'b1;
    tick();
    idle();
    check("unf_cleared", 32'(bus.underflow), 32'd0);

    // Join: flush on entry, double depth with pointer wrap
    push_word(32'h0BAD_0001, 1'b0);
    push_word(32'h0BAD_0002, 1'b0);
    check("pre_join_level", 32'(bus.level), 32'd2);
    bus.join_mode = 1'b1;
    tick();
    check("join_flush_level", 32'(bus.level), 32'd0);
    check("join_flush_dout", bus.dout, 32'd0);
    for (int i = 0; i < 7; i++) push_word(32'(i), 1'b1);
    check("join_full_at7", 32'(bus.full), 32'd0);
    check("join_level_7", 32'(bus.level), 32'd7);
    push_word(32'd7, 1'b1);
    check("join_full_at8", 32'(bus.full), 32'd1);
    check("join_level_8", 32'(bus.level), 32'd8);
    pull_n(3);
    for (int i = 8; i < 11; i++) push_word(32'(i), 1'b1);
    check("join_wrap_level", 32'(bus.level), 32'd8);
    check("join_wrap_head", bus.dout, 32'd3);
    pull_n(8);
    check("join_drain_empty", 32'(bus.empty), 32'd1);
    check("join_ovf_clean", 32'(bus.overflow), 32'd0);

    // Leave join: flush, and the push in the change cycle is ignored
    push_word(32'h0BAD_0003, 1'b0);
    push_word(32'h0BAD_0004, 1'b0);
    bus.join_mode = 1'b0;
    bus.push      = 1'b1;
    bus.din       = 32'h0BAD_0005;
    tick();
    idle();
    check("unjoin_level", 32'(bus.level), 32'd0);
    check("unjoin_empty", 32'(bus.empty), 32'd1);

    // Set beats clear, then clear alone
    for (int i = 0; i < 4; i++) push_word(32'hC000_0000 + 32'(i), 1'b1);
    bus.clear_flags = 1'b1;
    push_word(32'hFFFF_FFFF, 1'b0);
    bus.clear_flags = 1'b0;
    check("set_beats_clear", 32'(bus.overflow), 32'd1);
    bus.clear_flags = 1'b1;
    tick();
    idle();
    check("clear_alone", 32'(bus.overflow), 32'd0);
    pull_n(1);
    check("pre_reset_level", 32'(bus.level), 32'd3);

    // Reset mid-operation
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    check("midrst_level", 32'(bus.level), 32'd0);
    check("midrst_dout", bus.dout, 32'd0);
    check("midrst_empty", 32'(bus.empty), 32'd1);
    tick();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
